srff_flag_reader: RTL

//  Reader/clearer for a bank of W sticky SRFF event flags: the flag bank sets bits, this block consumes them.
//  - Round-robin scans flag_q and presents one pending flag index on a valid/ready port.
//  - On acceptance, pulses that flag's reset input for one cycle, then confirms it dropped.
//  - Sits between interrupt/event SRFF banks and a sequencer or CPU-side event queue.

---
 rtl/srff_flag_reader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/srff_flag_reader.sv
// Round-robin reader/clearer for a bank of sticky SRFF event flags.
// Optional overrun counter enabled by defining FLAG_READER_OVERRUN_EN.
module srff_flag_reader #(
  parameter int W     = 8,
  parameter int OVR_W = 8,
  localparam int IW   = $clog2(W)
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [W-1:0]     flag_q,
  output logic [W-1:0]     flag_r,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IW-1:0]    evt_idx,
  output logic             busy,
  output logic [OVR_W-1:0] ovr_cnt
);

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    PRESENT = 2'd1,
    CLEAR   = 2'd2,
    SETTLE  = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   last, last_nx;
  logic [IW-1:0]   idx_nx;
  logic            valid_nx;
  logic [W-1:0]    r_nx;
  logic            busy_nx;
  logic [IW:0]     pick;

  // First set bit after 'from', wrapping; MSB of the result is the found flag.
  function automatic logic [IW:0] rr_pick(input logic [W-1:0] flags, input logic [IW-1:0] from);
    int j;
    rr_pick = {(IW+1){1'b0}};
    for (int k = W; k >= 1; k--) begin
      j = (int'(from) + k) % W;
      if (flags[j]) begin
        rr_pick = {1'b1, IW'(j)};
      end
    end
  endfunction

`ifdef FLAG_READER_OVERRUN_EN
  logic [OVR_W-1:0] ovr_q, ovr_nx;
`endif

  // Next-state and next-output logic.
  always_comb begin
    pick     = rr_pick(flag_q, last);
    state_nx = state;
    last_nx  = last;
    idx_nx   = evt_idx;
    valid_nx = evt_valid;
    r_nx     = {W{1'b0}};
`ifdef FLAG_READER_OVERRUN_EN
    ovr_nx   = ovr_q;
`endif
    case (state)
      SCAN: begin
        if (pick[IW]) begin
          state_nx = PRESENT;
          idx_nx   = pick[IW-1:0];
          last_nx  = pick[IW-1:0];
          valid_nx = 1'b1;
        end else begin
          state_nx = SCAN;
        end
      end
      PRESENT: begin
        // The offer stands even if the flag drops externally meanwhile.
        if (evt_ready) begin
          state_nx = CLEAR;
          valid_nx = 1'b0;
          r_nx     = {{(W-1){1'b0}}, 1'b1} << evt_idx;
        end else begin
          valid_nx = 1'b1;
        end
      end
      CLEAR: begin
        state_nx = SETTLE;
      end
      SETTLE: begin
        // A flag still high here was re-set during the clear; a later scan picks it up.
`ifdef FLAG_READER_OVERRUN_EN
        if (flag_q[evt_idx] && (ovr_q != {OVR_W{1'b1}})) begin
          ovr_nx = ovr_q + {{(OVR_W-1){1'b0}}, 1'b1};
        end else begin
          ovr_nx = ovr_q;
        end
`endif
        state_nx = SCAN;
      end
      default: begin
        state_nx = SCAN;
        valid_nx = 1'b0;
      end
    endcase
    busy_nx = (state_nx != SCAN);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= SCAN;
      last      <= IW'(W-1);
      evt_idx   <= {IW{1'b0}};
      evt_valid <= 1'b0;
      flag_r    <= {W{1'b0}};
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      last      <= last_nx;
      evt_idx   <= idx_nx;
      evt_valid <= valid_nx;
      flag_r    <= r_nx;
      busy      <= busy_nx;
    end
  end

`ifdef FLAG_READER_OVERRUN_EN
  // Saturating overrun counter, cleared only by reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ovr_q <= {OVR_W{1'b0}};
    end else begin
      ovr_q <= ovr_nx;
    end
  end
  assign ovr_cnt = ovr_q;
`else
  assign ovr_cnt = {OVR_W{1'b0}};
`endif

endmodule
